// File: rtl/cprv_wb_arbiter.sv
// Writeback-stage register-file write-port arbiter: in-order pipeline vs. buffered
// long-latency results, with a busy scoreboard and anti-starvation forcing.
module cprv_wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned REGADDR_WIDTH = 5,
  parameter int unsigned BUF_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_valid_i,
  output logic                        pipe_ready_o,
  input  logic                        pipe_rd_en_i,
  input  logic [REGADDR_WIDTH-1:0]    pipe_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]       pipe_rd_data_i,
  input  logic                        ll_issue_i,
  input  logic [REGADDR_WIDTH-1:0]    ll_issue_rd_i,
  input  logic                        ll_valid_i,
  output logic                        ll_ready_o,
  input  logic [REGADDR_WIDTH-1:0]    ll_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]       ll_rd_data_i,
  output logic [2**REGADDR_WIDTH-1:0] busy_o,
  output logic                        rf_rd_en_o,
  output logic [REGADDR_WIDTH-1:0]    rf_rd_addr_o,
  output logic [DATA_WIDTH-1:0]       rf_rd_data_o
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG  = 2**REGADDR_WIDTH;

  logic [REGADDR_WIDTH-1:0] r_buf_rd   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]    r_buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]         r_wptr, r_rptr;
  logic [CNT_W-1:0]         r_count;
  logic [STV_W-1:0]         r_starve;
  logic [NREG-1:0]          r_busy;

  logic                     w_empty, w_full;
  logic [REGADDR_WIDTH-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0]    w_head_data;
  logic                     w_pipe_req, w_head_req, w_force;
  logic                     w_grant_head, w_grant_pipe;
  logic                     w_push, w_pop;
  logic [NREG-1:0]          w_busy_nxt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(BUF_DEPTH));
  assign w_head_rd   = r_buf_rd[r_rptr];
  assign w_head_data = r_buf_data[r_rptr];
  assign w_pipe_req  = pipe_valid_i & pipe_rd_en_i & (pipe_rd_addr_i != '0);
  assign w_head_req  = ~w_empty & (w_head_rd != '0);
  assign w_force     = w_head_req & (r_starve == STV_W'(STARVE_LIMIT));

  // A starved head steals the port; only a beat that actually writes is stalled.
  always_comb begin
    w_grant_head = 1'b0;
    w_grant_pipe = 1'b0;
    pipe_ready_o = 1'b1;
    if (!rst_n) begin
      pipe_ready_o = 1'b0;
    end else if (w_force) begin
      w_grant_head = 1'b1;
      pipe_ready_o = ~w_pipe_req;
    end else if (w_pipe_req) begin
      w_grant_pipe = 1'b1;
    end else if (w_head_req) begin
      w_grant_head = 1'b1;
    end
  end

  assign rf_rd_en_o   = w_grant_head | w_grant_pipe;
  assign rf_rd_addr_o = w_grant_head ? w_head_rd :
                        w_grant_pipe ? pipe_rd_addr_i : '0;
  assign rf_rd_data_o = w_grant_head ? w_head_data :
                        w_grant_pipe ? pipe_rd_data_i : '0;

  assign ll_ready_o = rst_n & ~w_full;
  assign w_push     = ll_valid_i & ll_ready_o;
  assign w_pop      = rst_n & ~w_empty & (w_grant_head | (w_head_rd == '0));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_head) w_busy_nxt[w_head_rd] = 1'b0;
    if (ll_issue_i && (ll_issue_rd_i != '0)) w_busy_nxt[ll_issue_rd_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_rd[r_wptr]   <= ll_rd_addr_i;
      r_buf_data[r_wptr] <= ll_rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_busy   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_empty || w_grant_head)
        r_starve <= '0;
      else if (w_head_req && (r_starve != STV_W'(STARVE_LIMIT)))
        r_starve <= r_starve + 1'b1;
      r_busy <= w_busy_nxt;
    end
  end

  // Re-issue is legal only when the previous write to that register retires this cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(ll_issue_i && (ll_issue_rd_i != '0) && r_busy[ll_issue_rd_i] &&
                !(w_grant_head && (w_head_rd == ll_issue_rd_i))));
      assert (!(w_pipe_req && r_busy[pipe_rd_addr_i]));
    end
  end

  assign busy_o = r_busy;

endmodule

// File: doc/cprv_wb_arbiter.md
Name: cprv_wb_arbiter

Overview:
Owns the single register-file write port in the writeback stage and shares it between two requesters.
- The in-order pipeline writeback has priority.
- A long-latency unit (mul/div, future FPU) returns results out of band into a small result buffer.
- A per-register busy scoreboard of outstanding long-latency destinations is exported so decode can stall RAW/WAW hazards.
- An anti-starvation counter guarantees buffered long-latency results eventually retire.

Parameters:
DATA_WIDTH, 64, register data width
REGADDR_WIDTH, 5, register address width (32 registers)
BUF_DEPTH, 2, long-latency result buffer entries (power of two, >=2)
STARVE_LIMIT, 4, cycles a buffered result may be denied before it is forced through

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pipe_valid_i  in  1  pipeline writeback beat valid
pipe_ready_o  out  1  pipeline beat accepted this cycle
pipe_rd_en_i  in  1  beat writes a register
pipe_rd_addr_i  in  REGADDR_WIDTH  pipeline destination
pipe_rd_data_i  in  DATA_WIDTH  pipeline result
ll_issue_i  in  1  long-latency op dispatched this cycle
ll_issue_rd_i  in  REGADDR_WIDTH  its destination register
ll_valid_i  in  1  long-latency result valid
ll_ready_o  out  1  result buffer not full
ll_rd_addr_i  in  REGADDR_WIDTH  result destination
ll_rd_data_i  in  DATA_WIDTH  result data
busy_o  out  2**REGADDR_WIDTH  scoreboard; bit r set = r has an outstanding long-latency write
rf_rd_en_o  out  1  register-file write enable
rf_rd_addr_o  out  REGADDR_WIDTH  register-file write address
rf_rd_data_o  out  DATA_WIDTH  register-file write data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). While rst_n=0 at a clk edge:
  - buffer emptied; busy_o=0; starve counter=0.
  - Combinational outputs forced inactive while rst_n=0: pipe_ready_o=0, ll_ready_o=0, rf_rd_en_o=0; rf address and data outputs are 0.
  - Reset mid-operation discards all buffered results and clears the scoreboard.
- Request definitions:
  - pipe_req = pipe_valid_i & pipe_rd_en_i & (pipe_rd_addr_i!=0).
  - head_req = buffer non-empty & (head rd != 0).
  - A head entry with rd=0 is popped in the cycle it reaches the head, without using the port.
- Grant, combinational, same cycle:
  - force = head_req & (starve_cnt==STARVE_LIMIT).
  - If force: the head is written and pipe_ready_o = ~pipe_req. A pipeline beat with no write passes; a writing beat stalls one cycle.
  - Else if pipe_req: the pipeline beat is written and pipe_ready_o=1.
  - Else if head_req: the head is written and pipe_ready_o=1.
  - Else: rf_rd_en_o=0 and pipe_ready_o=1.
- Write timing: the register file commits at the clk edge ending the grant cycle. Pipeline writeback latency is 0 cycles added.
- Result buffer: FIFO with BUF_DEPTH entries.
  - ll_ready_o = ~full.
  - Push on ll_valid_i & ll_ready_o.
  - Pop when the head is granted, or when the head has rd=0.
  - Simultaneous push and pop while full is not allowed, because ll_ready_o=0 when full. Simultaneous push and pop at any other occupancy keeps occupancy unchanged.
  - No bypass: an accepted result is written no earlier than the next cycle. Pointers wrap modulo BUF_DEPTH.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each cycle head_req=1 and the head is not granted.
  - Clears when the head is granted or the buffer is empty.
- Scoreboard:
  - Set busy[ll_issue_rd_i] on ll_issue_i when ll_issue_rd_i!=0.
  - Clear busy[rd] when an entry with that rd is written through the port.
  - Set and clear of the same register in the same cycle: set wins.
  - Issuing to an already-busy register is illegal; the simulation assertion fires. Decode must stall on busy_o.
  - busy_o[0] is always 0.
- Assertions:
  - ll_valid_i while ~ll_ready_o is tolerated and ignored; the source holds it.
  - pipe_req to a busy register is flagged as an error.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> rf_rd_en_o=0, ll_ready_o=0, busy_o=0. Release rst_n -> ll_ready_o=1 next cycle.
2. Pipeline only: pipe beat rd=5, data=0x1234 -> same cycle rf_rd_en_o=1, addr=5, data=0x1234, pipe_ready_o=1. Beat with rd=0 -> rf_rd_en_o=0.
3. Long-latency path:
   - Stimulus: ll_issue rd=7, so busy_o[7]=1 next cycle. Later ll_valid rd=7, data=0xAB, with the pipeline idle.
   - Response: the write appears the cycle after acceptance; busy_o[7] clears after that edge.
4. Starvation: BUF_DEPTH=2 buffer holds results rd=3 and rd=4, with a continuous pipe_req stream.
   - The rd=3 head is forced after 4 denied cycles: pipe_ready_o=0 for exactly 1 cycle, rf_rd_addr_o=3.
   - The counter restarts, and rd=4 is forced 4 cycles later.
   - ll_ready_o=0 while the buffer is full.
5. Same-cycle set/clear: an ll result writes rd=9 in the same cycle ll_issue_i targets rd=9 -> busy_o[9] stays 1.
6. Reset with 2 entries buffered and busy bits set -> buffer empty, busy_o=0, no stale rf writes after release.
